// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between NREQ requesters and the shared ALU arbiter.
// The rsp_flags signal is present only when ALU_FLAGS_EN is defined.
interface alu_share_arbiter_if #(
   parameter int N    = 8,
   parameter int NREQ = 4
);
   localparam int IW = $clog2(NREQ);

   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*N-1:0] req_a;
   logic [NREQ*N-1:0] req_b;
   logic [NREQ*2-1:0] req_ctl;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [N-1:0]      rsp_result;
   logic [IW-1:0]     rsp_id;
`ifdef ALU_FLAGS_EN
   logic [3:0]        rsp_flags;

   modport master (
      output req_valid, req_a, req_b, req_ctl, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_id, rsp_flags
   );

   modport slave (
      input  req_valid, req_a, req_b, req_ctl, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_id, rsp_flags
   );
`else
   modport master (
      output req_valid, req_a, req_b, req_ctl, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_id
   );

   modport slave (
      input  req_valid, req_a, req_b, req_ctl, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_id
   );
`endif

endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters, with a one-entry response buffer.
// Optional macro ALU_FLAGS_EN adds registered {N,Z,C,V} flags on rsp_flags.
module alu_share_arbiter #(
   parameter int N    = 8,
   parameter int NREQ = 4
) (
   input  logic                clk,
   input  logic                reset,
   alu_share_arbiter_if.slave  bus,
   output logic [15:0]         op_count
);

   localparam int IW = $clog2(NREQ);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [N-1:0]      rsp_result_q, rsp_result_d;
   logic [IW-1:0]     rsp_id_q, rsp_id_d;
   logic [15:0]       op_count_q, op_count_d;
`ifdef ALU_FLAGS_EN
   logic [3:0]        rsp_flags_q, rsp_flags_d;
`endif

   logic              grant_found;
   logic [IW-1:0]     grant_idx;
   logic              can_accept;
   logic              xfer;
   logic [NREQ-1:0]   req_ready;
   int                cand;

   logic [N-1:0]      sel_a;
   logic [N-1:0]      sel_b;
   logic [1:0]        sel_ctl;
   logic [N-1:0]      alu_res;

   // ctl[0] selects subtract: a + ~b + 1, wrapping modulo 2^N.
   function automatic logic [N-1:0] alu_op(input logic [N-1:0] a,
                                           input logic [N-1:0] b,
                                           input logic [1:0]   ctl);
      logic [N-1:0] bb;
      logic [N-1:0] r;
      bb = ctl[0] ? ~b : b;
      case (ctl)
         2'b10:   r = a & b;
         2'b11:   r = a | b;
         default: r = a + bb + N'(ctl[0]);
      endcase
      return r;
   endfunction

`ifdef ALU_FLAGS_EN
   function automatic logic [3:0] alu_flags(input logic [N-1:0] a,
                                            input logic [N-1:0] b,
                                            input logic [1:0]   ctl,
                                            input logic [N-1:0] r);
      logic [N-1:0] bb;
      logic [N:0]   sum;
      logic         c;
      logic         v;
      bb  = ctl[0] ? ~b : b;
      sum = {1'b0, a} + {1'b0, bb} + (N+1)'(ctl[0]);
      c   = ~ctl[1] & sum[N];
      v   = ~ctl[1] & (a[N-1] == bb[N-1]) & (r[N-1] != a[N-1]);
      return {r[N-1], (r == '0), c, v};
   endfunction
`endif

   // Search ptr, ptr+1, ... wrapping; first valid requester wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int k = 0; k < NREQ; k++) begin
         cand = int'(ptr_q) + k;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         if (!grant_found && bus.req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = IW'(cand);
         end
      end
   end

   assign can_accept = (state_q == EMPTY) || bus.rsp_ready;
   assign xfer       = grant_found && can_accept && !reset;

   always_comb begin
      req_ready = '0;
      if (xfer) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   assign sel_a   = bus.req_a[int'(grant_idx)*N +: N];
   assign sel_b   = bus.req_b[int'(grant_idx)*N +: N];
   assign sel_ctl = bus.req_ctl[int'(grant_idx)*2 +: 2];
   assign alu_res = alu_op(sel_a, sel_b, sel_ctl);

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      rsp_result_d = rsp_result_q;
      rsp_id_d     = rsp_id_q;
      op_count_d   = op_count_q;
`ifdef ALU_FLAGS_EN
      rsp_flags_d  = rsp_flags_q;
`endif
      if (xfer) begin
         state_d      = FULL;
         rsp_result_d = alu_res;
         rsp_id_d     = grant_idx;
         op_count_d   = op_count_q + 16'd1;
         ptr_d        = (int'(grant_idx) == NREQ-1) ? '0 : grant_idx + 1'b1;
`ifdef ALU_FLAGS_EN
         rsp_flags_d  = alu_flags(sel_a, sel_b, sel_ctl, alu_res);
`endif
      end else if (state_q == FULL && bus.rsp_ready) begin
         // Drained with nothing to refill; the result value is kept.
         state_d = EMPTY;
      end
   end

   // Response buffer register stage
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= EMPTY;
         ptr_q        <= '0;
         rsp_result_q <= '0;
         rsp_id_q     <= '0;
         op_count_q   <= '0;
`ifdef ALU_FLAGS_EN
         rsp_flags_q  <= 4'b0000;
`endif
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         rsp_result_q <= rsp_result_d;
         rsp_id_q     <= rsp_id_d;
         op_count_q   <= op_count_d;
`ifdef ALU_FLAGS_EN
         rsp_flags_q  <= rsp_flags_d;
`endif
      end
   end

   assign bus.req_ready  = req_ready;
   assign bus.rsp_valid  = (state_q == FULL);
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_id     = rsp_id_q;
`ifdef ALU_FLAGS_EN
   assign bus.rsp_flags  = rsp_flags_q;
`endif
   assign op_count       = op_count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter (N=8, NREQ=4); flag checks active with ALU_FLAGS_EN.
module tb_alu_share_arbiter;

   logic        clk;
   logic        reset;
   logic [15:0] op_count;
   int          checks;
   int          failures;

   alu_share_arbiter_if #(.N(8), .NREQ(4)) bus ();

   alu_share_arbiter #(.N(8), .NREQ(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .op_count (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] ctl);
      bus.req_a[i*8 +: 8]   = a;
      bus.req_b[i*8 +: 8]   = b;
      bus.req_ctl[i*2 +: 2] = ctl;
   endtask

   task automatic do_op(input string tag, input int i, input logic [7:0] a,
                        input logic [7:0] b, input logic [1:0] ctl,
                        input int exp_r, input int exp_f);
      set_req(i, a, b, ctl);
      bus.req_valid    = '0;
      bus.req_valid[i] = 1'b1;
      #1;
      chk({tag, "_ready"}, 32'(bus.req_ready), 32'(1 << i));
      step();
      bus.req_valid = '0;
      chk({tag, "_result"}, 32'(bus.rsp_result), 32'(exp_r));
      chk({tag, "_id"}, 32'(bus.rsp_id), 32'(i));
`ifdef ALU_FLAGS_EN
      chk({tag, "_flags"}, 32'(bus.rsp_flags), 32'(exp_f));
`else
      if (exp_f < 0) $display("note: negative flag expectation ignored");
`endif
   endtask

   initial begin
      checks         = 0;
      failures       = 0;
      reset          = 1'b1;
      bus.req_valid  = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.req_ctl    = '0;
      bus.rsp_ready  = 1'b1;
      step();
      step();

      // Reset state, then a single add from requester 0
      set_req(0, 8'h05, 8'h03, 2'b00);
      bus.req_valid = 4'b0001;
      #1;
      chk("rst_ready", 32'(bus.req_ready), 0);
      chk("rst_valid", 32'(bus.rsp_valid), 0);
      chk("rst_result", 32'(bus.rsp_result), 0);
      chk("rst_id", 32'(bus.rsp_id), 0);
      chk("rst_opcnt", 32'(op_count), 0);
      reset = 1'b0;
      #1;
      chk("t1_ready", 32'(bus.req_ready), 'b0001);
      step();
      bus.req_valid = '0;
      chk("t1_valid", 32'(bus.rsp_valid), 1);
      chk("t1_result", 32'(bus.rsp_result), 'h08);
      chk("t1_id", 32'(bus.rsp_id), 0);
      chk("t1_opcnt", 32'(op_count), 1);

      // Round-robin with all requesters valid: a=i+1, b=1, subtract
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) set_req(i, 8'(i + 1), 8'h01, 2'b01);
      bus.req_valid = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         #1;
         chk("rr_ready", 32'(bus.req_ready), 32'(1 << (g % 4)));
         step();
         chk("rr_result", 32'(bus.rsp_result), 32'(g % 4));
         chk("rr_id", 32'(bus.rsp_id), 32'(g % 4));
      end
      bus.req_valid = '0;
      chk("rr_opcnt", 32'(op_count), 5);

      // Backpressure: response held, requester 2 waits then wins on release
      bus.rsp_ready = 1'b0;
      set_req(2, 8'h10, 8'h20, 2'b00);
      bus.req_valid = 4'b0100;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("bp_ready", 32'(bus.req_ready), 0);
         step();
         chk("bp_valid", 32'(bus.rsp_valid), 1);
         chk("bp_result", 32'(bus.rsp_result), 'h00);
         chk("bp_id", 32'(bus.rsp_id), 0);
      end
      bus.rsp_ready = 1'b1;
      #1;
      chk("bp_rel_ready", 32'(bus.req_ready), 'b0100);
      step();
      bus.req_valid = '0;
      chk("bp_rel_result", 32'(bus.rsp_result), 'h30);
      chk("bp_rel_id", 32'(bus.rsp_id), 2);
      chk("bp_opcnt", 32'(op_count), 6);

      // Operation encodings and flag boundaries ({N,Z,C,V})
      do_op("and",  1, 8'hF0, 8'h3C, 2'b10, 'h30, 'b0000);
      do_op("or",   1, 8'hF0, 8'h3C, 2'b11, 'hFC, 'b1000);
      do_op("subw", 3, 8'h00, 8'h01, 2'b01, 'hFF, 'b1000);
      do_op("ovf",  0, 8'h7F, 8'h01, 2'b00, 'h80, 'b1001);
      do_op("carry",2, 8'hFF, 8'h01, 2'b00, 'h00, 'b0110);
      do_op("subc", 1, 8'h05, 8'h03, 2'b01, 'h02, 'b0010);
      chk("ops_opcnt", 32'(op_count), 12);

      // Reset while a response is buffered and requests pending
      bus.rsp_ready = 1'b0;
      set_req(0, 8'h11, 8'h22, 2'b00);
      bus.req_valid = 4'b1111;
      reset = 1'b1;
      #1;
      chk("mrst_ready_hi", 32'(bus.req_ready), 0);
      step();
      chk("mrst_valid", 32'(bus.rsp_valid), 0);
      chk("mrst_opcnt", 32'(op_count), 0);
      chk("mrst_ready", 32'(bus.req_ready), 0);
      chk("mrst_result", 32'(bus.rsp_result), 0);
      reset = 1'b0;
      #1;
      chk("mrst_prio", 32'(bus.req_ready), 'b0001);
      step();
      chk("mrst_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("mrst_rsp_id", 32'(bus.rsp_id), 0);
      chk("mrst_rsp_result", 32'(bus.rsp_result), 'h33);
      #1;
      chk("mrst_full_ready", 32'(bus.req_ready), 0);
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;

      // Op counter wrap after 65536 accepted ops
      reset = 1'b1;
      step();
      reset = 1'b0;
      set_req(0, 8'h01, 8'h01, 2'b00);
      bus.req_valid = 4'b0001;
      for (int n = 0; n < 65535; n++) step();
      chk("wrap_ffff", 32'(op_count), 'hFFFF);
      step();
      chk("wrap_zero", 32'(op_count), 0);
      bus.req_valid = '0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one Alu datapath (N-bit, 2-bit alu_ctl) among NREQ requesters, e.g. the execute stage plus the address-generation and debug ports.
- Grants access round-robin over valid/ready request channels.
- Registers each result into a one-entry response buffer with backpressure, tagged with the requester index.
- Sits between the requesters and a single Alu instance.

Parameters:
- N, 8, operand/result width in bits.
- NREQ, 4, number of requesters (>=2); IW = $clog2(NREQ).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester request accepted this cycle.
- req_a  input  NREQ*N  operand A, requester i at bits [i*N +: N].
- req_b  input  NREQ*N  operand B, same packing.
- req_ctl  input  NREQ*2  alu_ctl per requester: 00 add, 01 sub (a+~b+1), 10 and, 11 or.
- rsp_valid  output  1  response buffer holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_result  output  N  registered ALU result.
- rsp_id  output  IW  index of the requester that produced rsp_result.
- op_count  output  16  number of accepted requests, wraps.

Behaviour:
- Reset (sync, active-high): rsp_valid=0, rsp_result=0, rsp_id=0, op_count=0, round-robin pointer ptr=0. req_ready=0 while reset is high. Reset mid-operation drops any buffered response with no rsp handshake.
- States:
  - EMPTY (rsp_valid=0).
  - FULL (rsp_valid=1).
- can_accept = EMPTY, or FULL with rsp_ready=1 (pass-through refill in the same cycle).
- Arbitration: combinational.
  - Grant goes to the first i with req_valid[i]=1, searching ptr, ptr+1, ..., wrapping modulo NREQ.
  - req_ready[i] = can_accept & grant[i]. At most one bit is set.
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Transfer on req_valid[i] & req_ready[i]. At the next clk edge:
  - rsp_result = ALU(req_a[i], req_b[i], req_ctl[i]), truncated to N bits.
  - rsp_id = i, rsp_valid = 1.
  - ptr = (i+1) mod NREQ.
  - op_count += 1; 16'hFFFF wraps to 0.
- Latency: 1 cycle from request handshake to rsp_valid. Throughput: 1 op/cycle while rsp_ready stays high.
- FULL with rsp_ready=0: rsp_result and rsp_id are held stable, no grants, ptr unchanged.
- FULL with rsp_ready=1 and no request: next state EMPTY; rsp_result holds its last value.
- ptr does not move on cycles without a transfer, so an unserved requester keeps its turn.
- Requesters hold operands stable while valid and not ready. The block does not check this.
- Arithmetic matches the Alu encoding exactly:
  - Sub is two's complement, wraps modulo 2^N.
  - Carry-out is discarded unless ALU_FLAGS_EN is defined.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- When defined: adds output rsp_flags, 4 bits {N,Z,C,V}, registered alongside rsp_result with the same hold rules; reset value 4'b0000.
  - N = result[N-1].
  - Z = (result==0).
  - C = bit N of a+condinvb+ctl[0] for ctl 0x; 0 for logic ops.
  - V = signed overflow for add/sub; 0 for logic ops.
- When undefined: port and flag logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset, then req_valid[0]=1, a=8'h05, b=8'h03, ctl=00 -> req_ready[0]=1 same cycle; next cycle rsp_valid=1, rsp_result=8'h08, rsp_id=0, op_count=1.
- All four valid, rsp_ready held 1, each a=i+1, b=1, ctl=01 -> grants 0,1,2,3,0 on consecutive cycles; results 00,01,02,03,00; ptr wraps.
- Response pending, rsp_ready=0 for 3 cycles with req_valid[2]=1 -> req_ready all 0, rsp_result/rsp_id stable; on rsp_ready=1, requester 2 is granted in that same cycle.
- ctl=10 a=8'hF0 b=8'h3C -> 8'h30; ctl=11 -> 8'hFC; ctl=01 a=8'h00 b=8'h01 -> 8'hFF; with ALU_FLAGS_EN, flags=4'b1000 for 8'hFF, and a=8'h7F b=8'h01 ctl=00 -> 8'h80, flags 4'b1001.
- Reset asserted while rsp_valid=1 and requests pending -> next cycle rsp_valid=0, op_count=0, req_ready=0; after release requester 0 has priority.
- 65536 accepted ops -> op_count returns to 16'h0000.
